spike_encoder: RTL and testbench
================================

Name: spike_encoder

Overview:
- Input-side spike generator for the SNN datapath.
- Accepts one multi-channel 8-bit sample per valid/ready handshake.
- Converts each channel into a fixed-length spike train of WINDOW_LEN timesteps, using rate (sigma-delta) coding or latency (time-to-first-spike) coding.
- Spike outputs drive the input-layer synapse/LIF neurons.

Parameters:
- NUM_CHANNELS, 2, number of independent encoder channels.
- WIDTH_P, 8, bits per channel sample.
- WINDOW_LEN, 16, timesteps emitted per sample; legal range 2..65535.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- data_i  input  NUM_CHANNELS*WIDTH_P  packed samples; channel c occupies bits [c*WIDTH_P +: WIDTH_P].
- valid_i  input  1  sample offered.
- ready_o  output  1  encoder can accept a sample.
- mode_i  input  1  coding mode; 0 = rate, 1 = latency; sampled with data.
- spike_o  output  NUM_CHANNELS  per-channel spike for the current timestep.
- step_o  output  1  a timestep is being presented this cycle.
- last_o  output  1  final timestep of the window.
- busy_o  output  1  window in progress.

Behaviour:
- Reset (async, rst_ni=0):
  - state = IDLE; spike_o, step_o, last_o, busy_o = 0; ready_o = 1.
  - Timestep counter, latched samples, latched mode and phase accumulators all cleared.
  - Reset asserted mid-window aborts the window immediately, with no further spikes.
- FSM states: IDLE, RUN.
- IDLE:
  - ready_o = 1 (decoded from state, no combinational path from valid_i).
  - On the edge where valid_i & ready_o: latch data_i and mode_i, clear accumulators, t = 0, go to RUN.
- RUN:
  - ready_o = 0, busy_o = 1.
  - Each rising edge computes timestep t for every channel and registers spike_o, step_o = 1, last_o = (t == WINDOW_LEN-1), then increments t.
  - On the edge registering t = WINDOW_LEN-1, go to IDLE.
  - valid_i and data_i are ignored in RUN; the latched copy is used.
- Latency and timing:
  - Acceptance at edge E0 puts timestep 0 on the outputs after E0+1 and timestep t after E0+1+t.
  - ready_o is low for exactly WINDOW_LEN cycles.
  - With valid_i held high, back-to-back frames have exactly one cycle of step_o = 0 between windows.
- Outside step_o = 1, spike_o = 0 and last_o = 0.
- busy_o = 1 from E0 through the cycle showing last_o.
- Rate mode, per channel:
  - Accumulator is WIDTH_P+1 bits: sum = acc + d.
  - spike = sum[WIDTH_P] (carry).
  - acc <= sum[WIDTH_P-1:0].
  - Spikes per window = floor(WINDOW_LEN*d / 2^WIDTH_P); d = 0 gives no spikes.
- Latency mode, per channel:
  - Target tt = ((2^WIDTH_P-1-d) * WINDOW_LEN) >> WIDTH_P, computed at acceptance with full-width product, no overflow.
  - Exactly one spike at t == tt if d != 0; d = 0 gives no spike.
- Channels are fully independent; no cross-channel interaction.
- mode_i changes mid-window have no effect on the current window.

Test Plan:
- Rate mode, WINDOW_LEN=16, ch0 d=128, ch1 d=0 -> ch0 spikes at t=1,3,5,...,15 (8 spikes), ch1 none; step_o high 16 consecutive cycles starting one cycle after acceptance; last_o only at t=15.
- Rate mode, d=255 on both channels -> 15 spikes each, the only silent step is t=0; d=1 -> 0 spikes.
- Latency mode, ch0 d=128, ch1 d=255 -> ch0 single spike at t=7, ch1 single spike at t=0; d=1 -> spike at t=15; d=0 -> no spike.
- valid_i held high with two samples queued -> ready_o low exactly 16 cycles per frame; one idle cycle (step_o=0) between frames; second frame uses its own data/mode; data changes during RUN have no effect.
- rst_ni pulled low asynchronously at t=5 of a rate window -> spike_o, step_o, last_o, busy_o go 0 without waiting for a clock; ready_o=1; after release the next accepted d=128 sample again spikes first at t=1 (accumulator cleared).
- mode_i toggled mid-window -> current window keeps its latched mode; next window uses the mode sampled at its acceptance.

Source files
------------

// File: rtl/spike_encoder_if.sv
// Sample handshake bundle between the sample source and the spike encoder.
// The master offers packed channel samples and a coding mode; the slave answers with ready.
interface spike_encoder_if #(
    parameter int NUM_CHANNELS = 2,
    parameter int WIDTH_P      = 8
);
    logic [NUM_CHANNELS*WIDTH_P-1:0] data_i;
    logic                            valid_i;
    logic                            mode_i;
    logic                            ready_o;

    modport master (output data_i, output valid_i, output mode_i, input ready_o);
    modport slave  (input data_i, input valid_i, input mode_i, output ready_o);
endinterface

// File: rtl/spike_encoder.sv
// Converts one multi-channel sample into a WINDOW_LEN-step spike train per channel,
// using sigma-delta rate coding (mode 0) or time-to-first-spike latency coding (mode 1).
module spike_encoder #(
    parameter int NUM_CHANNELS = 2,
    parameter int WIDTH_P      = 8,
    parameter int WINDOW_LEN   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    spike_encoder_if.slave          in_if,
    output logic [NUM_CHANNELS-1:0] spike_o,
    output logic                    step_o,
    output logic                    last_o,
    output logic                    busy_o
);
    localparam int TW = $clog2(WINDOW_LEN);
    localparam int PW = WIDTH_P + 16;
    localparam logic [0:0]    S_IDLE   = 1'b0;
    localparam logic [0:0]    S_RUN    = 1'b1;
    localparam logic [TW-1:0] T_LAST   = TW'(WINDOW_LEN - 1);
    localparam logic [PW-1:0] WLEN_EXT = PW'(WINDOW_LEN);

    logic [0:0]                           state_q, state_d;
    logic [TW-1:0]                        t_q, t_d;
    logic [NUM_CHANNELS-1:0][WIDTH_P-1:0] data_q, data_d;
    logic [NUM_CHANNELS-1:0][WIDTH_P-1:0] acc_q, acc_d;
    logic [NUM_CHANNELS-1:0][TW-1:0]      tgt_q, tgt_d;
    logic                                 mode_q, mode_d;
    logic [NUM_CHANNELS-1:0]              spike_q, spike_d;
    logic                                 step_q, step_d;
    logic                                 last_q, last_d;
    logic                                 busy_q, busy_d;

    logic [NUM_CHANNELS-1:0][WIDTH_P:0]   sum_s;
    logic [NUM_CHANNELS-1:0][WIDTH_P-1:0] inv_s;
    logic [NUM_CHANNELS-1:0][PW-1:0]      prod_s;

    assign in_if.ready_o = (state_q == S_IDLE);
    assign spike_o       = spike_q;
    assign step_o        = step_q;
    assign last_o        = last_q;
    assign busy_o        = busy_q;

    // Next-state, per-channel encoding and registered-output decode.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        data_d  = data_q;
        acc_d   = acc_q;
        tgt_d   = tgt_q;
        mode_d  = mode_q;
        spike_d = '0;
        step_d  = 1'b0;
        last_d  = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            sum_s[c]  = {1'b0, acc_q[c]} + {1'b0, data_q[c]};
            inv_s[c]  = ~in_if.data_i[c*WIDTH_P +: WIDTH_P];
            // (2^W-1-d)*WINDOW_LEN at full width; the shifted result is always < WINDOW_LEN
            prod_s[c] = {16'h0000, inv_s[c]} * WLEN_EXT;
        end
        case (state_q)
            S_IDLE: begin
                if (in_if.valid_i) begin
                    state_d = S_RUN;
                    t_d     = '0;
                    mode_d  = in_if.mode_i;
                    for (int c = 0; c < NUM_CHANNELS; c++) begin
                        data_d[c] = in_if.data_i[c*WIDTH_P +: WIDTH_P];
                        acc_d[c]  = '0;
                        tgt_d[c]  = TW'(prod_s[c] >> WIDTH_P);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                step_d = 1'b1;
                last_d = (t_q == T_LAST);
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    if (mode_q) begin
                        spike_d[c] = (data_q[c] != '0) && (t_q == tgt_q[c]);
                    end else begin
                        spike_d[c] = sum_s[c][WIDTH_P];
                        acc_d[c]   = sum_s[c][WIDTH_P-1:0];
                    end
                end
                if (t_q == T_LAST) begin
                    state_d = S_IDLE;
                    t_d     = '0;
                end else begin
                    t_d = t_q + TW'(1'b1);
                end
            end
            default: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
        endcase
        busy_d = (state_d == S_RUN) || (state_q == S_RUN);
    end

    // State and output registers; reset aborts any window in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            data_q  <= '0;
            acc_q   <= '0;
            tgt_q   <= '0;
            mode_q  <= 1'b0;
            spike_q <= '0;
            step_q  <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
            tgt_q   <= tgt_d;
            mode_q  <= mode_d;
            spike_q <= spike_d;
            step_q  <= step_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_spike_encoder.sv
// Directed bench for spike_encoder with NUM_CHANNELS=2, WIDTH_P=8, WINDOW_LEN=16.
module tb_spike_encoder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] spike;
    logic       step, last, busy;
    int         pass_cnt  = 0;
    int         total_cnt = 0;

    logic [15:0] s0, s1, st, ls, bz;
    logic [2:0]  pre;
    logic [4:0]  post;
    logic [39:0] v_step, v_rdy, v_sp0, v_sp1;
    logic [39:0] e_step, e_rdy, e_sp0, e_sp1;

    spike_encoder_if #(.NUM_CHANNELS(2), .WIDTH_P(8)) bus ();

    spike_encoder #(.NUM_CHANNELS(2), .WIDTH_P(8), .WINDOW_LEN(16)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .in_if   (bus),
        .spike_o (spike),
        .step_o  (step),
        .last_o  (last),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Offer one sample, then record the 16 timesteps plus the cycles before and after.
    task automatic do_window(input logic [15:0] d, input logic m,
                             output logic [15:0] o_s0, output logic [15:0] o_s1,
                             output logic [15:0] o_st, output logic [15:0] o_ls,
                             output logic [15:0] o_bz, output logic [2:0] o_pre,
                             output logic [4:0] o_post);
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.data_i  = d;
        bus.mode_i  = m;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        @(negedge clk);
        o_pre = {busy, step, bus.ready_o};
        for (int t = 0; t < 16; t++) begin
            @(posedge clk);
            @(negedge clk);
            o_s0[t] = spike[0];
            o_s1[t] = spike[1];
            o_st[t] = step;
            o_ls[t] = last;
            o_bz[t] = busy;
        end
        @(negedge clk);
        o_post = {|spike, step, last, busy, bus.ready_o};
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.valid_i = 1'b0;
        bus.data_i  = 16'h0000;
        bus.mode_i  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", {spike, step, last, busy, bus.ready_o}, 6'b000001);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {spike, step, last, busy, bus.ready_o}, 6'b000001);

        // Rate: ch0=128, ch1=0
        do_window({8'd0, 8'd128}, 1'b0, s0, s1, st, ls, bz, pre, post);
        chk("rate128_ch0", s0, 16'hAAAA);
        chk("rate0_ch1", s1, 16'h0000);
        chk("rate_steps", st, 16'hFFFF);
        chk("rate_last", ls, 16'h8000);
        chk("rate_busy", bz, 16'hFFFF);
        chk("rate_pre", pre, 3'b100);
        chk("rate_post", post, 5'b00001);

        // Rate: ch0=255, ch1=1
        do_window({8'd1, 8'd255}, 1'b0, s0, s1, st, ls, bz, pre, post);
        chk("rate255_ch0", s0, 16'hFFFE);
        chk("rate1_ch1", s1, 16'h0000);
        chk("rate2_last", ls, 16'h8000);

        // Latency: ch0=128 -> t7, ch1=255 -> t0
        do_window({8'd255, 8'd128}, 1'b1, s0, s1, st, ls, bz, pre, post);
        chk("lat128_ch0", s0, 16'h0080);
        chk("lat255_ch1", s1, 16'h0001);
        chk("lat_steps", st, 16'hFFFF);
        chk("lat_post", post, 5'b00001);

        // Latency: ch0=1 -> t15, ch1=0 -> none
        do_window({8'd0, 8'd1}, 1'b1, s0, s1, st, ls, bz, pre, post);
        chk("lat1_ch0", s0, 16'h8000);
        chk("lat0_ch1", s1, 16'h0000);

        // Back-to-back with valid held; data/mode changed while running
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.data_i  = {8'd0, 8'd128};
        bus.mode_i  = 1'b0;
        @(posedge clk);
        #1;
        bus.data_i = {8'd255, 8'd255};
        bus.mode_i = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            v_step[k] = step;
            v_rdy[k]  = bus.ready_o;
            v_sp0[k]  = spike[0];
            v_sp1[k]  = spike[1];
            if (k == 17) bus.valid_i = 1'b0;
            if (k == 20) begin
                bus.data_i = 16'h0000;
                bus.mode_i = 1'b0;
            end
        end
        for (int k = 0; k < 40; k++) begin
            e_step[k] = ((k >= 1) && (k <= 16)) || ((k >= 18) && (k <= 33));
            e_rdy[k]  = !((k <= 15) || ((k >= 17) && (k <= 32)));
            e_sp0[k]  = ((k >= 2) && (k <= 16) && (k % 2 == 0)) || (k == 18);
            e_sp1[k]  = (k == 18);
        end
        chk("b2b_step", v_step, e_step);
        chk("b2b_ready", v_rdy, e_rdy);
        chk("b2b_ch0", v_sp0, e_sp0);
        chk("b2b_ch1", v_sp1, e_sp1);

        // Asynchronous reset at t=5 of a rate window
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.data_i  = {8'd255, 8'd128};
        bus.mode_i  = 1'b0;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_t5", {spike, step, busy}, 4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {spike, step, last, busy, bus.ready_o}, 6'b000001);
        @(negedge clk);
        rst_n = 1'b1;
        do_window({8'd0, 8'd128}, 1'b0, s0, s1, st, ls, bz, pre, post);
        chk("post_rst_ch0", s0, 16'hAAAA);
        chk("post_rst_pre", pre, 3'b100);
        chk("post_rst_last", ls, 16'h8000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
